// File: rtl/gate_debounce_pkg.sv
// Shared types and defaults for the gate input debouncer: per-channel FSM
// states, the default stability window and the counter sizing helper.
package gate_debounce_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } deb_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/gate_debounce_bit.sv
// One debounced channel: two-flop synchroniser, stability counter/FSM,
// output bubble and optional edge pulses (macro GATE_DEBOUNCE_EDGE_EN).
module gate_debounce_bit
  import gate_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit BUBBLE          = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic stable,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int              CNT_W  = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit              SINGLE = (DEBOUNCE_CYCLES == 1);

  logic             meta_p0;
  logic             sync_p1;
  logic             deb;
  logic             deb_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  deb_state_t       state;
  deb_state_t       state_nxt;

  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c);
    if (c >= LAST) return LAST;
    return c + CNT_W'(1);
  endfunction

  // Stage p0/p1: synchroniser for the asynchronous pin
  always_ff @(posedge clock) begin
    if (reset) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      meta_p0 <= din;
      sync_p1 <= meta_p0;
    end
  end

  // Stability FSM: state, counter and accepted level
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      deb   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      deb   <= deb_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    deb_nxt   = deb;
    case (state)
      IDLE: begin
        if (sync_p1 != deb) begin
          // A one-cycle window accepts the new level immediately.
          if (SINGLE) begin
            deb_nxt = ~deb;
            cnt_nxt = '0;
          end else begin
            state_nxt = PENDING;
            cnt_nxt   = CNT_W'(1);
          end
        end
      end
      PENDING: begin
        if (sync_p1 == deb) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt >= LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          deb_nxt   = ~deb;
        end else begin
          cnt_nxt = cnt_step(cnt);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign dout   = deb ^ BUBBLE;
  assign stable = (state == IDLE);

`ifdef GATE_DEBOUNCE_EDGE_EN
  logic dout_p2;

  // Stage p2: previous output, reset to the bubble so reset never pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      dout_p2 <= BUBBLE;
    end else begin
      dout_p2 <= dout;
    end
  end

  assign rise_pulse = dout & ~dout_p2;
  assign fall_pulse = ~dout & dout_p2;
`else
  assign rise_pulse = 1'b0;
  assign fall_pulse = 1'b0;
`endif

endmodule

// File: rtl/gate_input_debouncer.sv
// WIDTH independent debounced gate inputs with per-channel output bubbles;
// edge pulses are built only when GATE_DEBOUNCE_EDGE_EN is defined.
module gate_input_debouncer
  import gate_debounce_pkg::*;
#(
  parameter int               WIDTH           = 2,
  parameter int               DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic [WIDTH-1:0] BubblesMask     = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] stable,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    gate_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .BUBBLE         (BubblesMask[g])
    ) u_bit (
      .clock     (clock),
      .reset     (reset),
      .din       (data_in[g]),
      .dout      (data_out[g]),
      .stable    (stable[g]),
      .rise_pulse(rise_pulse[g]),
      .fall_pulse(fall_pulse[g])
    );
  end

endmodule

// File: tb/tb_gate_input_debouncer.sv
// Bench for gate_input_debouncer: directed table, corner sequences and a
// randomized run against a mismatch-streak reference model.
module tb_gate_input_debouncer;

`ifdef GATE_DEBOUNCE_EDGE_EN
  localparam logic [1:0] EDGE = 2'b11;
`else
  localparam logic [1:0] EDGE = 2'b00;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] data_in;
  logic [1:0] out_a, stb_a, rise_a, fall_a;
  logic [1:0] out_b, stb_b, rise_b, fall_b;
  logic [1:0] out_c, stb_c, rise_c, fall_c;

  always #5 clock = ~clock;

  gate_input_debouncer #(.WIDTH(2), .DEBOUNCE_CYCLES(4), .BubblesMask(2'b10)) u_a (
    .clock(clock), .reset(reset), .data_in(data_in), .data_out(out_a),
    .stable(stb_a), .rise_pulse(rise_a), .fall_pulse(fall_a));

  gate_input_debouncer #(.WIDTH(2), .DEBOUNCE_CYCLES(4), .BubblesMask(2'b01)) u_b (
    .clock(clock), .reset(reset), .data_in(data_in), .data_out(out_b),
    .stable(stb_b), .rise_pulse(rise_b), .fall_pulse(fall_b));

  gate_input_debouncer #(.WIDTH(2), .DEBOUNCE_CYCLES(1), .BubblesMask(2'b00)) u_c (
    .clock(clock), .reset(reset), .data_in(data_in), .data_out(out_c),
    .stable(stb_c), .rise_pulse(rise_c), .fall_pulse(fall_c));

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference model: a level is accepted once sync has disagreed with it for
  // DEBOUNCE_CYCLES consecutive edges; any agreement restarts the streak.
  int         dcyc[3] = '{4, 4, 1};
  logic [1:0] msk[3]  = '{2'b10, 2'b01, 2'b00};
  logic [1:0] m_s1[3], m_s2[3], m_deb[3], m_prev[3];
  int         m_run[3][2];

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_s1[k] = '0; m_s2[k] = '0; m_deb[k] = '0; m_prev[k] = msk[k];
      m_run[k][0] = 0; m_run[k][1] = 0;
    end
  end

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      m_prev[k] = m_deb[k] ^ msk[k];
      if (reset) begin
        m_s1[k] = '0; m_s2[k] = '0; m_deb[k] = '0; m_prev[k] = msk[k];
        m_run[k][0] = 0; m_run[k][1] = 0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (m_s2[k][i] != m_deb[k][i]) begin
            m_run[k][i] = m_run[k][i] + 1;
            if (m_run[k][i] >= dcyc[k]) begin
              m_deb[k][i] = ~m_deb[k][i];
              m_run[k][i] = 0;
            end
          end else begin
            m_run[k][i] = 0;
          end
        end
        m_s2[k] = m_s1[k];
        m_s1[k] = data_in;
      end
    end
  endtask

  function automatic logic [1:0] e_out(input int k);
    return m_deb[k] ^ msk[k];
  endfunction
  function automatic logic [1:0] e_stb(input int k);
    return {m_run[k][1] == 0, m_run[k][0] == 0};
  endfunction
  function automatic logic [1:0] e_rise(input int k);
    return e_out(k) & ~m_prev[k] & EDGE;
  endfunction
  function automatic logic [1:0] e_fall(input int k);
    return ~e_out(k) & m_prev[k] & EDGE;
  endfunction

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic check_model(input int n);
    chk($sformatf("rnd%0d_out_a", n), out_a, e_out(0));
    chk($sformatf("rnd%0d_stb_a", n), stb_a, e_stb(0));
    chk($sformatf("rnd%0d_rise_a", n), rise_a, e_rise(0));
    chk($sformatf("rnd%0d_fall_a", n), fall_a, e_fall(0));
    chk($sformatf("rnd%0d_out_b", n), out_b, e_out(1));
    chk($sformatf("rnd%0d_stb_b", n), stb_b, e_stb(1));
    chk($sformatf("rnd%0d_rise_b", n), rise_b, e_rise(1));
    chk($sformatf("rnd%0d_fall_b", n), fall_b, e_fall(1));
    chk($sformatf("rnd%0d_out_c", n), out_c, e_out(2));
    chk($sformatf("rnd%0d_stb_c", n), stb_c, e_stb(2));
    chk($sformatf("rnd%0d_rise_c", n), rise_c, e_rise(2));
    chk($sformatf("rnd%0d_fall_c", n), fall_c, e_fall(2));
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] din;
    logic [1:0] out_a, stb, rise_a, fall_a, out_b, rise_b, fall_b;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [1:0] din, input logic [1:0] oa,
                     input logic [1:0] st, input logic [1:0] ra, input logic [1:0] fa,
                     input logic [1:0] ob, input logic [1:0] rb, input logic [1:0] fb);
    vec_t v;
    v.rst = rst; v.din = din; v.out_a = oa; v.stb = st; v.rise_a = ra;
    v.fall_a = fa; v.out_b = ob; v.rise_b = rb; v.fall_b = fb;
    tbl.push_back(v);
  endtask

  initial begin
    reset   = 1'b1;
    data_in = 2'b00;

    // reset, then clean rise on channel 0 (accepted on the sixth edge)
    add(1, 2'b00, 2'b10, 2'b11, 0, 0, 2'b01, 0, 0);
    add(1, 2'b00, 2'b10, 2'b11, 0, 0, 2'b01, 0, 0);
    add(0, 2'b01, 2'b10, 2'b11, 0, 0, 2'b01, 0, 0);
    add(0, 2'b01, 2'b10, 2'b11, 0, 0, 2'b01, 0, 0);
    add(0, 2'b01, 2'b10, 2'b10, 0, 0, 2'b01, 0, 0);
    add(0, 2'b01, 2'b10, 2'b10, 0, 0, 2'b01, 0, 0);
    add(0, 2'b01, 2'b10, 2'b10, 0, 0, 2'b01, 0, 0);
    add(0, 2'b01, 2'b11, 2'b11, 2'b01, 0, 2'b00, 0, 2'b01);
    add(0, 2'b01, 2'b11, 2'b11, 0, 0, 2'b00, 0, 0);
    add(0, 2'b01, 2'b11, 2'b11, 0, 0, 2'b00, 0, 0);
    // three-cycle glitch on channel 1 is rejected
    add(0, 2'b11, 2'b11, 2'b11, 0, 0, 2'b00, 0, 0);
    add(0, 2'b11, 2'b11, 2'b11, 0, 0, 2'b00, 0, 0);
    add(0, 2'b11, 2'b11, 2'b01, 0, 0, 2'b00, 0, 0);
    add(0, 2'b01, 2'b11, 2'b01, 0, 0, 2'b00, 0, 0);
    add(0, 2'b01, 2'b11, 2'b01, 0, 0, 2'b00, 0, 0);
    add(0, 2'b01, 2'b11, 2'b11, 0, 0, 2'b00, 0, 0);
    add(0, 2'b01, 2'b11, 2'b11, 0, 0, 2'b00, 0, 0);
    // reset from an accepted level, then reset in the middle of a pending rise
    add(1, 2'b00, 2'b10, 2'b11, 0, 0, 2'b01, 0, 0);
    add(0, 2'b01, 2'b10, 2'b11, 0, 0, 2'b01, 0, 0);
    add(0, 2'b01, 2'b10, 2'b11, 0, 0, 2'b01, 0, 0);
    add(0, 2'b01, 2'b10, 2'b10, 0, 0, 2'b01, 0, 0);
    add(1, 2'b00, 2'b10, 2'b11, 0, 0, 2'b01, 0, 0);
    add(0, 2'b00, 2'b10, 2'b11, 0, 0, 2'b01, 0, 0);
    add(0, 2'b00, 2'b10, 2'b11, 0, 0, 2'b01, 0, 0);
    add(0, 2'b00, 2'b10, 2'b11, 0, 0, 2'b01, 0, 0);

    foreach (tbl[n]) begin
      reset   = tbl[n].rst;
      data_in = tbl[n].din;
      step();
      chk($sformatf("tbl%0d_out_a", n), out_a, tbl[n].out_a);
      chk($sformatf("tbl%0d_stb_a", n), stb_a, tbl[n].stb);
      chk($sformatf("tbl%0d_rise_a", n), rise_a, tbl[n].rise_a & EDGE);
      chk($sformatf("tbl%0d_fall_a", n), fall_a, tbl[n].fall_a & EDGE);
      chk($sformatf("tbl%0d_out_b", n), out_b, tbl[n].out_b);
      chk($sformatf("tbl%0d_stb_b", n), stb_b, tbl[n].stb);
      chk($sformatf("tbl%0d_rise_b", n), rise_b, tbl[n].rise_b & EDGE);
      chk($sformatf("tbl%0d_fall_b", n), fall_b, tbl[n].fall_b & EDGE);
    end

    // a pulse of exactly DEBOUNCE_CYCLES is accepted, then debounced back
    reset = 1'b0;
    data_in = 2'b01;
    for (int s = 0; s < 4; s++) step();
    data_in = 2'b00;
    step();
    chk("exact_pulse_before", out_a, 2'b10);
    step();
    chk("exact_pulse_taken", out_a, 2'b11);
    chk("exact_pulse_rise", rise_a, 2'b01 & EDGE);
    for (int s = 0; s < 3; s++) step();
    chk("exact_pulse_hold", out_a, 2'b11);
    step();
    chk("exact_pulse_back", out_a, 2'b10);
    chk("exact_pulse_fall", fall_a, 2'b01 & EDGE);

    // single-cycle window: accepted on the third edge, never pending
    for (int s = 0; s < 4; s++) step();
    data_in = 2'b10;
    step();
    step();
    chk("d1_before", out_c, 2'b00);
    chk("d1_stb_before", stb_c, 2'b11);
    step();
    chk("d1_taken", out_c, 2'b10);
    chk("d1_rise", rise_c, 2'b10 & EDGE);
    chk("d1_stb", stb_c, 2'b11);
    step();
    chk("d1_rise_gone", rise_c, 2'b00);

    // randomized run against the reference model
    reset = 1'b1;
    step();
    check_model(-1);
    for (int n = 0; n < 1500; n++) begin
      reset = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 3) == 0) data_in = 2'($urandom);
      step();
      check_model(n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
